// File: rtl/uart_host_burst_if.sv
// Memory-bus bundle between the UART bridge (master) and on-chip memory (slave).
// wvalid/rvalid stay high with address/wdata stable until the cycle where the matching
// wready/rready is high; rrvalid is a one-cycle pulse that carries rdata.
interface uart_host_burst_if #(
  parameter int ADDR_BYTE = 4,
  parameter int DATA_BYTE = 4
);
  logic [8*ADDR_BYTE-1:0] address;
  logic                   wvalid;
  logic [8*DATA_BYTE-1:0] wdata;
  logic                   wready;
  logic                   rvalid;
  logic                   rready;
  logic                   rrvalid;
  logic [8*DATA_BYTE-1:0] rdata;

  modport master (
    output address, wvalid, wdata, rvalid,
    input  wready, rready, rrvalid, rdata
  );

  modport slave (
    input  address, wvalid, wdata, rvalid,
    output wready, rready, rrvalid, rdata
  );
endinterface

// File: rtl/uart_host_burst.sv
// UART command decoder that runs 1-256 word burst reads/writes on the memory bus,
// plus the 8N1 uart_core it talks through.
module uart_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg_div,
  input  logic        cfg_txen,
  input  logic        cfg_rxen,
  input  logic        cfg_nstop,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        txd,
  input  logic        rxd
);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        r_tx_busy;
  logic [10:0] r_tx_sh;
  logic [3:0]  r_tx_bits;
  logic [15:0] r_tx_tmr;

  rx_state_t   r_rx_state, w_rx_next;
  logic        r_rx_s1, r_rx_s2;
  logic [15:0] r_rx_tmr;
  logic [2:0]  r_rx_bits;
  logic [7:0]  r_rx_sh;
  logic        r_rx_valid;
  logic        w_rx_tick;

  assign tx_ready  = cfg_txen && !r_tx_busy;
  assign txd       = r_tx_sh[0];
  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_sh;
  assign w_rx_tick = (r_rx_tmr == 16'd0);

  // Shifter refills with ones, so its LSB doubles as the idle-high line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_busy <= 1'b0;
      r_tx_sh   <= '1;
      r_tx_bits <= '0;
      r_tx_tmr  <= '0;
    end else if (!r_tx_busy) begin
      if (tx_valid && tx_ready) begin
        r_tx_busy <= 1'b1;
        r_tx_sh   <= {2'b11, tx_data, 1'b0};
        r_tx_bits <= cfg_nstop ? 4'd11 : 4'd10;
        r_tx_tmr  <= cfg_div;
      end
    end else if (r_tx_tmr == 16'd0) begin
      r_tx_tmr  <= cfg_div;
      r_tx_sh   <= {1'b1, r_tx_sh[10:1]};
      r_tx_bits <= r_tx_bits - 4'd1;
      if (r_tx_bits == 4'd1) r_tx_busy <= 1'b0;
    end else begin
      r_tx_tmr <= r_tx_tmr - 16'd1;
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (cfg_rxen && !r_rx_s2) w_rx_next = RX_START;
      RX_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bits == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  // Start edge preloads half a bit so every later sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_tmr   <= '0;
      r_rx_bits  <= '0;
      r_rx_sh    <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_s1    <= rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        RX_IDLE: r_rx_tmr <= {1'b0, cfg_div[15:1]};
        RX_START: begin
          if (w_rx_tick) begin
            r_rx_tmr  <= cfg_div;
            r_rx_bits <= '0;
          end else begin
            r_rx_tmr <= r_rx_tmr - 16'd1;
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_sh   <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_bits <= r_rx_bits + 3'd1;
            r_rx_tmr  <= cfg_div;
          end else begin
            r_rx_tmr <= r_rx_tmr - 16'd1;
          end
        end
        RX_STOP: begin
          if (w_rx_tick) r_rx_valid <= r_rx_s2;
          else           r_rx_tmr   <= r_rx_tmr - 16'd1;
        end
        default: r_rx_tmr <= '0;
      endcase
    end
  end
endmodule

module uart_host_burst #(
  parameter int ADDR_BYTE = 4,
  parameter int DATA_BYTE = 4,
  parameter int BAUD_RATE = 115200,
  parameter int CLK_FREQ  = 100000000,
  parameter int TIMEOUT   = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    uart_txd,
  input  logic                    uart_rxd,
  input  logic                    enable,
  uart_host_burst_if.master       bus,
  output logic [3:0]              dbg_state
);
  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_ADDR, S_WDATA, S_WREQ, S_RREQ, S_RWAIT, S_SEND, S_RESP
  } state_t;

  localparam int              AW        = 8 * ADDR_BYTE;
  localparam int              DW        = 8 * DATA_BYTE;
  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam int              DIV       = CLK_FREQ / BAUD_RATE - 1;
  localparam logic [2:0]      ADDR_LAST = 3'(ADDR_BYTE - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BYTE - 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0]   ADDR_STEP = AW'(DATA_BYTE);
  localparam logic [7:0]      ST_OK     = 8'hA5;
  localparam logic [7:0]      ST_ERR    = 8'hEE;

  state_t        r_state, w_next_state;
  logic          r_is_write, r_cmd_err;
  logic [8:0]    r_words;
  logic [2:0]    r_byte_cnt;
  logic [TW-1:0] r_tmo;
  logic [AW-1:0] r_address;
  logic [DW-1:0] r_wdata, r_rdata;
  logic          r_wvalid, r_rvalid;
  logic [7:0]    r_status;

  logic          w_rx_valid;
  logic [7:0]    w_rx_data;
  logic          w_tx_valid, w_tx_ready;
  logic [7:0]    w_tx_data;
  logic [15:0]   w_cfg_div;
  logic          w_tmo, w_w_hs, w_r_hs, w_state_chg;

  assign w_cfg_div   = 16'(DIV);
  assign w_tmo       = (r_tmo == TMO_LAST);
  assign w_w_hs      = r_wvalid && bus.wready;
  assign w_r_hs      = r_rvalid && bus.rready;
  assign w_state_chg = (w_next_state != r_state);

  assign bus.address = r_address;
  assign bus.wdata   = r_wdata;
  assign bus.wvalid  = r_wvalid;
  assign bus.rvalid  = r_rvalid;
  assign dbg_state   = r_state;

  uart_core u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_div   (w_cfg_div),
    .cfg_txen  (enable),
    .cfg_rxen  (enable),
    .cfg_nstop (1'b0),
    .tx_valid  (w_tx_valid),
    .tx_ready  (w_tx_ready),
    .tx_data   (w_tx_data),
    .rx_valid  (w_rx_valid),
    .rx_data   (w_rx_data),
    .txd       (uart_txd),
    .rxd       (uart_rxd)
  );

  // A received byte or a completed handshake always takes priority over a timeout.
  always_comb begin
    w_next_state = r_state;
    w_tx_valid   = 1'b0;
    w_tx_data    = r_status;
    case (r_state)
      S_IDLE: if (w_rx_valid) w_next_state = S_LEN;
      S_LEN: begin
        if (w_rx_valid) w_next_state = S_ADDR;
        else if (w_tmo) w_next_state = S_IDLE;
      end
      S_ADDR: begin
        if (w_rx_valid) begin
          if (r_byte_cnt == ADDR_LAST) begin
            if (r_cmd_err)       w_next_state = S_RESP;
            else if (r_is_write) w_next_state = S_WDATA;
            else                 w_next_state = S_RREQ;
          end
        end else if (w_tmo) begin
          w_next_state = S_IDLE;
        end
      end
      S_WDATA: begin
        if (w_rx_valid) begin
          if (r_byte_cnt == DATA_LAST) w_next_state = S_WREQ;
        end else if (w_tmo) begin
          w_next_state = S_IDLE;
        end
      end
      S_WREQ: begin
        if (w_w_hs)     w_next_state = (r_words == 9'd1) ? S_RESP : S_WDATA;
        else if (w_tmo) w_next_state = S_RESP;
      end
      S_RREQ: begin
        if (w_r_hs)     w_next_state = S_RWAIT;
        else if (w_tmo) w_next_state = S_RESP;
      end
      S_RWAIT: begin
        if (bus.rrvalid) w_next_state = S_SEND;
        else if (w_tmo)  w_next_state = S_RESP;
      end
      S_SEND: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_rdata[7:0];
        if (w_tx_ready && r_byte_cnt == DATA_LAST)
          w_next_state = (r_words != 9'd0) ? S_RREQ : S_IDLE;
      end
      S_RESP: begin
        w_tx_valid = 1'b1;
        if (w_tx_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_is_write <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_words    <= '0;
      r_byte_cnt <= '0;
      r_tmo      <= '0;
      r_address  <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_wvalid   <= 1'b0;
      r_rvalid   <= 1'b0;
      r_status   <= '0;
    end else begin
      if (w_state_chg || w_rx_valid) r_tmo <= '0;
      else if (!w_tmo)               r_tmo <= r_tmo + TW'(1);

      // Requests rise one cycle into WREQ/RREQ and drop on the leaving edge.
      r_wvalid <= (r_state == S_WREQ) && (w_next_state == S_WREQ);
      r_rvalid <= (r_state == S_RREQ) && (w_next_state == S_RREQ);

      if (w_state_chg && w_next_state == S_RESP)
        r_status <= (r_state == S_WREQ && w_w_hs) ? ST_OK : ST_ERR;

      case (r_state)
        S_IDLE: begin
          if (w_rx_valid) begin
            r_is_write <= (w_rx_data == 8'h02);
            r_cmd_err  <= (w_rx_data != 8'h01) && (w_rx_data != 8'h02);
          end
        end
        S_LEN: begin
          if (w_rx_valid) begin
            r_words    <= {1'b0, w_rx_data} + 9'd1;
            r_byte_cnt <= '0;
          end
        end
        S_ADDR: begin
          if (w_rx_valid) begin
            r_address[{r_byte_cnt, 3'b000} +: 8] <= w_rx_data;
            r_byte_cnt <= (r_byte_cnt == ADDR_LAST) ? 3'd0 : r_byte_cnt + 3'd1;
          end
        end
        S_WDATA: begin
          if (w_rx_valid) begin
            r_wdata[{r_byte_cnt, 3'b000} +: 8] <= w_rx_data;
            r_byte_cnt <= (r_byte_cnt == DATA_LAST) ? 3'd0 : r_byte_cnt + 3'd1;
          end
        end
        S_WREQ: begin
          if (w_w_hs) begin
            r_address <= r_address + ADDR_STEP;
            r_words   <= r_words - 9'd1;
          end
        end
        S_RWAIT: begin
          if (bus.rrvalid) begin
            r_rdata    <= bus.rdata;
            r_address  <= r_address + ADDR_STEP;
            r_words    <= r_words - 9'd1;
            r_byte_cnt <= '0;
          end
        end
        S_SEND: begin
          if (w_tx_ready) begin
            r_rdata    <= r_rdata >> 8;
            r_byte_cnt <= (r_byte_cnt == DATA_LAST) ? 3'd0 : r_byte_cnt + 3'd1;
          end
        end
        default: ;
      endcase

      // Gap timeouts, errors and bus timeouts all abandon whatever words are left.
      if (w_state_chg && (w_next_state == S_IDLE || w_next_state == S_RESP)) begin
        r_words    <= '0;
        r_byte_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_host_burst.sv
// Directed bench: bit-banged host UART, auto-acking memory responder, byte scoreboard.
module tb_uart_host_burst;
  localparam int AB   = 4;
  localparam int DB   = 4;
  localparam int BAUD = 125000;
  localparam int CLKF = 1000000;
  localparam int TMO  = 200;
  localparam int BITC = CLKF / BAUD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_txd;
  logic       uart_rxd = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] dbg_state;

  uart_host_burst_if #(.ADDR_BYTE(AB), .DATA_BYTE(DB)) bus ();

  uart_host_burst #(
    .ADDR_BYTE(AB), .DATA_BYTE(DB), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF), .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_txd  (uart_txd),
    .uart_rxd  (uart_rxd),
    .enable    (enable),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] exp_wa_q[$], exp_wd_q[$], exp_ra_q[$];
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$], rd_mem_q[$];

  logic        bus_ack = 1'b1;
  logic        rd_pending = 1'b0;
  logic [31:0] rd_next = '0;
  int          wv_total = 0;
  int          rv_total = 0;

  // Memory responder: acks a held request on the next negedge, returns read data one cycle later.
  always @(negedge clk) begin
    bus.wready  = 1'b0;
    bus.rready  = 1'b0;
    bus.rrvalid = 1'b0;
    bus.rdata   = '0;
    if (bus.wvalid) wv_total++;
    if (bus.rvalid) rv_total++;
    if (rd_pending) begin
      bus.rrvalid = 1'b1;
      bus.rdata   = rd_next;
      rd_pending  = 1'b0;
    end else if (bus_ack) begin
      if (bus.wvalid) begin
        bus.wready = 1'b1;
        wr_addr_q.push_back(bus.address);
        wr_data_q.push_back(bus.wdata);
      end else if (bus.rvalid) begin
        bus.rready = 1'b1;
        rd_addr_q.push_back(bus.address);
        rd_next    = (rd_mem_q.size() != 0) ? rd_mem_q.pop_front() : 32'hDEADBEEF;
        rd_pending = 1'b1;
      end
    end
  end

  // Host-side UART receiver for bytes the DUT transmits.
  always begin
    logic [7:0] b;
    @(negedge uart_txd);
    repeat (BITC / 2) @(negedge clk);
    if (uart_txd == 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (BITC) @(negedge clk);
        b[i] = uart_txd;
      end
      repeat (BITC) @(negedge clk);
      got_q.push_back(b);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rxd = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BITC) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (BITC + 2) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [7:0] len, input logic [31:0] addr);
    send_byte(cmd);
    send_byte(len);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic check_tx(input string tag);
    int n;
    n = exp_q.size();
    for (int c = 0; c < 4000 && got_q.size() < n; c++) @(negedge clk);
    check({tag, "_count"}, got_q.size(), n);
    while (exp_q.size() != 0) begin
      logic [63:0] obs;
      obs = (got_q.size() != 0) ? {56'd0, got_q.pop_front()} : 64'hBAD0BAD0;
      check({tag, "_byte"}, obs, {56'd0, exp_q.pop_front()});
    end
    repeat (150) @(negedge clk);
    check({tag, "_extra"}, got_q.size(), 0);
  endtask

  task automatic check_bus(input string tag);
    check({tag, "_nwr"}, wr_addr_q.size(), exp_wa_q.size());
    check({tag, "_nrd"}, rd_addr_q.size(), exp_ra_q.size());
    while (exp_wa_q.size() != 0) begin
      check({tag, "_waddr"}, (wr_addr_q.size() != 0) ? wr_addr_q.pop_front() : 32'hBAD0BAD0,
            exp_wa_q.pop_front());
      check({tag, "_wdata"}, (wr_data_q.size() != 0) ? wr_data_q.pop_front() : 32'hBAD0BAD0,
            exp_wd_q.pop_front());
    end
    while (exp_ra_q.size() != 0)
      check({tag, "_raddr"}, (rd_addr_q.size() != 0) ? rd_addr_q.pop_front() : 32'hBAD0BAD0,
            exp_ra_q.pop_front());
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  initial begin
    int v0, lows, cyc;
    enable   = 1'b1;
    uart_rxd = 1'b1;
    rst_n    = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_wvalid", bus.wvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_address", bus.address, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_txd", uart_txd, 1);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    got_q.delete();

    // single write
    send_hdr(8'h02, 8'h00, 32'h10);
    send_word(32'h12345678);
    exp_q.push_back(8'hA5);
    check_tx("single_wr");
    exp_wa_q.push_back(32'h10); exp_wd_q.push_back(32'h12345678);
    check_bus("single_wr");
    check("single_wr_idle", dbg_state, 0);

    // burst write, three words
    send_hdr(8'h02, 8'h02, 32'h100);
    send_word(32'hA3A2A1A0);
    send_word(32'hB3B2B1B0);
    send_word(32'hC3C2C1C0);
    exp_q.push_back(8'hA5);
    check_tx("burst_wr");
    exp_wa_q.push_back(32'h100); exp_wd_q.push_back(32'hA3A2A1A0);
    exp_wa_q.push_back(32'h104); exp_wd_q.push_back(32'hB3B2B1B0);
    exp_wa_q.push_back(32'h108); exp_wd_q.push_back(32'hC3C2C1C0);
    check_bus("burst_wr");

    // burst read, two words
    rd_mem_q.push_back(32'hAABBCCDD);
    rd_mem_q.push_back(32'h11223344);
    send_hdr(8'h01, 8'h01, 32'h200);
    exp_q.push_back(8'hDD); exp_q.push_back(8'hCC); exp_q.push_back(8'hBB); exp_q.push_back(8'hAA);
    exp_q.push_back(8'h44); exp_q.push_back(8'h33); exp_q.push_back(8'h22); exp_q.push_back(8'h11);
    check_tx("burst_rd");
    exp_ra_q.push_back(32'h200); exp_ra_q.push_back(32'h204);
    check_bus("burst_rd");

    // bus timeout: nobody answers the read request
    bus_ack = 1'b0;
    v0 = rv_total;
    send_hdr(8'h01, 8'h00, 32'h300);
    exp_q.push_back(8'hEE);
    check_tx("bus_tmo");
    check("bus_tmo_rvalid_len_ok", ((rv_total - v0) >= TMO - 2) && ((rv_total - v0) <= TMO), 1);
    check("bus_tmo_rvalid_low", bus.rvalid, 0);
    check("bus_tmo_state", dbg_state, 0);
    bus_ack = 1'b1;
    rd_mem_q.push_back(32'hCAFEF00D);
    send_hdr(8'h01, 8'h00, 32'h40);
    exp_q.push_back(8'h0D); exp_q.push_back(8'hF0); exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
    check_tx("after_tmo_rd");
    exp_ra_q.push_back(32'h40);
    check_bus("after_tmo_rd");

    // bad command consumes LEN/ADDR, no bus access, error status
    v0 = wv_total + rv_total;
    send_hdr(8'h7F, 8'h00, 32'h20);
    exp_q.push_back(8'hEE);
    check_tx("bad_cmd");
    check("bad_cmd_no_bus", (wv_total + rv_total) - v0, 0);
    check_bus("bad_cmd");

    // rx gap timeout after two bytes
    send_byte(8'h02);
    send_byte(8'h00);
    repeat (2 * TMO + 50) @(negedge clk);
    check("gap_state", dbg_state, 0);
    check("gap_no_tx", got_q.size(), 0);
    send_hdr(8'h02, 8'h00, 32'h30);
    send_word(32'h0BADF00D);
    exp_q.push_back(8'hA5);
    check_tx("after_gap_wr");
    exp_wa_q.push_back(32'h30); exp_wd_q.push_back(32'h0BADF00D);
    check_bus("after_gap_wr");

    // reset while the first read byte is on the wire
    rd_mem_q.push_back(32'h55AA55AA);
    send_hdr(8'h01, 8'h00, 32'h50);
    for (cyc = 0; cyc < 2000 && dbg_state != 4'd7; cyc++) @(negedge clk);
    check("rst_send_reached", dbg_state, 7);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_send_txd", uart_txd, 1);
    check("rst_send_state", dbg_state, 0);
    check("rst_send_address", bus.address, 0);
    rst_n = 1'b1;
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (uart_txd == 1'b0) lows++;
    end
    check("rst_send_quiet", lows, 0);
    got_q.delete();
    exp_ra_q.push_back(32'h50);
    check_bus("rst_send");
    rd_mem_q.push_back(32'h87654321);
    send_hdr(8'h01, 8'h00, 32'h60);
    exp_q.push_back(8'h21); exp_q.push_back(8'h43); exp_q.push_back(8'h65); exp_q.push_back(8'h87);
    check_tx("after_rst_rd");
    exp_ra_q.push_back(32'h60);
    check_bus("after_rst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
